mem_arbiter: RTL and testbench

- Responder for both memory buses the CPU core initiates: the instruction fetch bus and the data/IO bus.
- Arbitrates the two requesters onto one downstream memory port (`q_m_*`), with one transaction in flight at a time.
- Forwards the downstream ack and read data back to whichever requester was granted.
- Sits between the core and the SRAM/SDRAM/IO decode logic at top level.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the core's instruction-fetch and data/IO buses onto
// one downstream memory port, one transaction in flight at a time.
//
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous
// requests in IDLE alternate between instr and data. When it is undefined,
// data always wins and no last-grant register exists.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instr_m_*         fetch requester (addr/access in, ack/data_in out)
//   data_m_*, d_io    data/IO requester (addr/data/wr/bytesel/access in,
//                     ack/data_in out)
//   q_m_*             downstream port; the request side is registered, and
//                     q_m_ack/q_m_data_in come back from memory
module mem_arbiter #(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:1]   instr_m_addr,
  input  logic                  instr_m_access,
  output logic                  instr_m_ack,
  output logic [15:0]           instr_m_data_in,
  input  logic [ADDR_WIDTH:1]   data_m_addr,
  input  logic [15:0]           data_m_data_out,
  input  logic                  data_m_access,
  input  logic                  data_m_wr_en,
  input  logic [1:0]            data_m_bytesel,
  input  logic                  d_io,
  output logic                  data_m_ack,
  output logic [15:0]           data_m_data_in,
  output logic [ADDR_WIDTH:1]   q_m_addr,
  output logic [15:0]           q_m_data_out,
  output logic                  q_m_access,
  output logic                  q_m_wr_en,
  output logic [1:0]            q_m_bytesel,
  output logic                  q_m_io,
  input  logic                  q_m_ack,
  input  logic [15:0]           q_m_data_in
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_WIDTH:1] addr_q;
  logic [15:0]         data_out_q;
  logic                access_q;
  logic                wr_en_q;
  logic [1:0]          bytesel_q;
  logic                io_q;
  logic                grant_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = the last completed transaction belonged to data; reset value is INSTR.
  logic last_data_q;

  always_comb grant_data = data_m_access && (!instr_m_access || !last_data_q);
`else
  always_comb grant_data = data_m_access;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_out_q <= '0;
      access_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      bytesel_q  <= '0;
      io_q       <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            addr_q     <= data_m_addr;
            data_out_q <= data_m_data_out;
            wr_en_q    <= data_m_wr_en;
            bytesel_q  <= data_m_bytesel;
            io_q       <= d_io;
            access_q   <= 1'b1;
            state_q    <= SERVE_DATA;
          end else if (instr_m_access) begin
            addr_q     <= instr_m_addr;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            bytesel_q  <= '1;
            io_q       <= 1'b0;
            access_q   <= 1'b1;
            state_q    <= SERVE_INSTR;
          end else begin
            access_q   <= 1'b0;
          end
        end
        SERVE_INSTR, SERVE_DATA: begin
          // addr/data_out/bytesel keep their last values after completion.
          if (q_m_ack) begin
            access_q <= 1'b0;
            wr_en_q  <= 1'b0;
            io_q     <= 1'b0;
            state_q  <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_data_q <= (state_q == SERVE_DATA);
`endif
          end
        end
        default: begin
          access_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    instr_m_ack     = (state_q == SERVE_INSTR) && q_m_ack;
    data_m_ack      = (state_q == SERVE_DATA) && q_m_ack;
    instr_m_data_in = instr_m_ack ? q_m_data_in : '0;
    data_m_data_in  = data_m_ack ? q_m_data_in : '0;
  end

  assign q_m_addr     = addr_q;
  assign q_m_data_out = data_out_q;
  assign q_m_access   = access_q;
  assign q_m_wr_en    = wr_en_q;
  assign q_m_bytesel  = bytesel_q;
  assign q_m_io       = io_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, contention and reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_io;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  int checks;
  int errors;

  mem_arbiter #(.ADDR_WIDTH(19)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_m_addr    (instr_m_addr),
    .instr_m_access  (instr_m_access),
    .instr_m_ack     (instr_m_ack),
    .instr_m_data_in (instr_m_data_in),
    .data_m_addr     (data_m_addr),
    .data_m_data_out (data_m_data_out),
    .data_m_access   (data_m_access),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel),
    .d_io            (d_io),
    .data_m_ack      (data_m_ack),
    .data_m_data_in  (data_m_data_in),
    .q_m_addr        (q_m_addr),
    .q_m_data_out    (q_m_data_out),
    .q_m_access      (q_m_access),
    .q_m_wr_en       (q_m_wr_en),
    .q_m_bytesel     (q_m_bytesel),
    .q_m_io          (q_m_io),
    .q_m_ack         (q_m_ack),
    .q_m_data_in     (q_m_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ia;
    logic [19:1] iaddr;
    logic        da;
    logic [19:1] daddr;
    logic [15:0] ddo;
    logic        dwr;
    logic [1:0]  dbs;
    logic        dio;
    logic        qack;
    logic [15:0] qdin;
    logic        e_acc;
    logic [19:1] e_addr;
    logic [15:0] e_do;
    logic        e_wr;
    logic [1:0]  e_bs;
    logic        e_io;
    logic        e_iack;
    logic [15:0] e_idin;
    logic        e_dack;
    logic [15:0] e_ddin;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic acc, input logic [19:1] addr,
                          input logic [15:0] dout, input logic wr, input logic [1:0] bs,
                          input logic io, input logic iack, input logic [15:0] idin,
                          input logic dack, input logic [15:0] ddin);
    chk({tag, "_q_acc"},  32'(q_m_access),      32'(acc));
    chk({tag, "_q_addr"}, 32'(q_m_addr),        32'(addr));
    chk({tag, "_q_do"},   32'(q_m_data_out),    32'(dout));
    chk({tag, "_q_wr"},   32'(q_m_wr_en),       32'(wr));
    chk({tag, "_q_bs"},   32'(q_m_bytesel),     32'(bs));
    chk({tag, "_q_io"},   32'(q_m_io),          32'(io));
    chk({tag, "_iack"},   32'(instr_m_ack),     32'(iack));
    chk({tag, "_idin"},   32'(instr_m_data_in), 32'(idin));
    chk({tag, "_dack"},   32'(data_m_ack),      32'(dack));
    chk({tag, "_ddin"},   32'(data_m_data_in),  32'(ddin));
  endtask

  task automatic clear_inputs();
    instr_m_addr    = '0;
    instr_m_access  = 1'b0;
    data_m_addr     = '0;
    data_m_data_out = '0;
    data_m_access   = 1'b0;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = '0;
    d_io            = 1'b0;
    q_m_ack         = 1'b0;
    q_m_data_in     = '0;
  endtask

  // Asserted at +1 after an edge; returns at +1 after the next edge, IDLE.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_pulse_acc", 32'(q_m_access), 32'd0);
    step();
    reset = 1'b0;
  endtask

  // Reference model: which requester owns the port (0 none, 1 instr, 2 data)
  // and what the downstream request fields should currently read.
  int          m_owner;
  logic        m_last_data;
  logic        m_acc;
  logic [19:1] m_addr;
  logic [15:0] m_do;
  logic        m_wr;
  logic [1:0]  m_bs;
  logic        m_io;

  vec_t vt[11];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam int NCONT = 4;
  logic cont_is_data[NCONT] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
  localparam int NCONT = 3;
  logic cont_is_data[NCONT] = '{1'b1, 1'b1, 1'b1};
`endif

  initial begin
    logic        found;
    logic        ip, dp;
    logic        e_iack, e_dack;
    logic        take_data;
    logic [31:0] r;

    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    #1;
    chk_port("reset", 1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    step();
    reset = 1'b0;

    // ia, iaddr, da, daddr, ddo, dwr, dbs, dio, qack, qdin |
    // acc, addr, do, wr, bs, io, iack, idin, dack, ddin
    vt[0]  = '{1'b1, 19'h00100, 1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0,
               1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[1]  = '{1'b1, 19'h00100, 1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0,
               1'b1, 19'h00100, 16'h0, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[2]  = vt[1];
    vt[3]  = '{1'b1, 19'h00100, 1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b1, 16'hBEEF,
               1'b1, 19'h00100, 16'h0, 1'b0, 2'd3, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0};
    vt[4]  = '{1'b0, 19'h0, 1'b1, 19'h7FFFF, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0,
               1'b0, 19'h00100, 16'h0, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[5]  = '{1'b0, 19'h0, 1'b1, 19'h7FFFF, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0,
               1'b1, 19'h7FFFF, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[6]  = '{1'b0, 19'h0, 1'b1, 19'h7FFFF, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b1, 16'h5555,
               1'b1, 19'h7FFFF, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555};
    vt[7]  = '{1'b0, 19'h0, 1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b1, 16'hFFFF,
               1'b0, 19'h7FFFF, 16'h1234, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[8]  = '{1'b0, 19'h0, 1'b1, 19'h00020, 16'h0, 1'b0, 2'd3, 1'b1, 1'b0, 16'h0,
               1'b0, 19'h7FFFF, 16'h1234, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
    vt[9]  = '{1'b0, 19'h0, 1'b1, 19'h00020, 16'h0, 1'b0, 2'd3, 1'b1, 1'b1, 16'h00A5,
               1'b1, 19'h00020, 16'h0, 1'b0, 2'd3, 1'b1, 1'b0, 16'h0, 1'b1, 16'h00A5};
    vt[10] = '{1'b0, 19'h0, 1'b0, 19'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0,
               1'b0, 19'h00020, 16'h0, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};

    for (int i = 0; i < 11; i++) begin
      instr_m_access  = vt[i].ia;
      instr_m_addr    = vt[i].iaddr;
      data_m_access   = vt[i].da;
      data_m_addr     = vt[i].daddr;
      data_m_data_out = vt[i].ddo;
      data_m_wr_en    = vt[i].dwr;
      data_m_bytesel  = vt[i].dbs;
      d_io            = vt[i].dio;
      q_m_ack         = vt[i].qack;
      q_m_data_in     = vt[i].qdin;
      #1;
      chk_port($sformatf("vec%0d", i), vt[i].e_acc, vt[i].e_addr, vt[i].e_do, vt[i].e_wr,
               vt[i].e_bs, vt[i].e_io, vt[i].e_iack, vt[i].e_idin, vt[i].e_dack, vt[i].e_ddin);
      step();
    end

    // Contention: both requesters held continuously.
    clear_inputs();
    pulse_reset();
    instr_m_access = 1'b1;
    instr_m_addr   = 19'h11111;
    data_m_access  = 1'b1;
    data_m_addr    = 19'h22222;
    data_m_bytesel = 2'b11;
    for (int k = 0; k < NCONT; k++) begin
      step();
      q_m_ack     = 1'b1;
      q_m_data_in = 16'(k + 16'h0100);
      #1;
      chk($sformatf("cont%0d_addr", k), 32'(q_m_addr),
          cont_is_data[k] ? 32'h22222 : 32'h11111);
      chk($sformatf("cont%0d_dack", k), 32'(data_m_ack), 32'(cont_is_data[k]));
      chk($sformatf("cont%0d_iack", k), 32'(instr_m_ack), 32'(!cont_is_data[k]));
      step();
      q_m_ack = 1'b0;
`ifndef MEM_ARBITER_ROUND_ROBIN_EN
      if (k == NCONT - 1) data_m_access = 1'b0;
`endif
    end
`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    step();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h4321;
    #1;
    chk("cont_instr_addr", 32'(q_m_addr), 32'h11111);
    chk("cont_instr_iack", 32'(instr_m_ack), 32'd1);
    chk("cont_instr_idin", 32'(instr_m_data_in), 32'h4321);
    step();
    q_m_ack = 1'b0;
`endif
    clear_inputs();
    step();

    // Reset in the middle of a data transaction.
    data_m_access   = 1'b1;
    data_m_addr     = 19'h00ABC;
    data_m_data_out = 16'h0077;
    data_m_wr_en    = 1'b1;
    data_m_bytesel  = 2'b10;
    step();
    #1;
    chk("rmid_acc_before", 32'(q_m_access), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rmid_acc_async", 32'(q_m_access), 32'd0);
    chk("rmid_addr_async", 32'(q_m_addr), 32'd0);
    chk("rmid_wr_async", 32'(q_m_wr_en), 32'd0);
    data_m_access = 1'b0;
    step();
    reset       = 1'b0;
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hDEAD;
    #1;
    chk("rmid_late_dack", 32'(data_m_ack), 32'd0);
    chk("rmid_late_ddin", 32'(data_m_data_in), 32'd0);
    step();
    clear_inputs();
    instr_m_access = 1'b1;
    instr_m_addr   = 19'h00300;
    found = 1'b0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (q_m_access) begin
        found = 1'b1;
        break;
      end
    end
    chk("rmid_fetch_granted", 32'(found), 32'd1);
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hCAFE;
    #1;
    chk("rmid_fetch_addr", 32'(q_m_addr), 32'h00300);
    chk("rmid_fetch_iack", 32'(instr_m_ack), 32'd1);
    chk("rmid_fetch_idin", 32'(instr_m_data_in), 32'hCAFE);
    step();
    clear_inputs();
    step();

    // Randomized traffic against the reference model.
    pulse_reset();
    m_owner     = 0;
    m_last_data = 1'b0;
    m_acc       = 1'b0;
    m_addr      = '0;
    m_do        = '0;
    m_wr        = 1'b0;
    m_bs        = '0;
    m_io        = 1'b0;
    ip = 1'b0;
    dp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1'b1;
        r = $urandom;
        instr_m_addr = r[18:0];
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1'b1;
        r = $urandom;
        data_m_addr = r[18:0];
        r = $urandom;
        data_m_data_out = r[15:0];
        data_m_wr_en    = r[16];
        data_m_bytesel  = r[18:17];
        d_io            = r[19];
      end
      instr_m_access = ip;
      data_m_access  = dp;
      q_m_ack        = ($urandom_range(0, 2) == 0);
      r = $urandom;
      q_m_data_in    = r[15:0];
      #1;
      e_iack = (m_owner == 1) && q_m_ack;
      e_dack = (m_owner == 2) && q_m_ack;
      chk_port("rand", m_acc, m_addr, m_do, m_wr, m_bs, m_io,
               e_iack, e_iack ? q_m_data_in : 16'h0,
               e_dack, e_dack ? q_m_data_in : 16'h0);
      // Advance the model across the coming clock edge.
      if (m_owner == 0) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        take_data = dp && (!ip || !m_last_data);
`else
        take_data = dp;
`endif
        if (take_data) begin
          m_owner = 2;
          m_acc = 1'b1; m_addr = data_m_addr; m_do = data_m_data_out;
          m_wr = data_m_wr_en; m_bs = data_m_bytesel; m_io = d_io;
        end else if (ip) begin
          m_owner = 1;
          m_acc = 1'b1; m_addr = instr_m_addr; m_do = '0;
          m_wr = 1'b0; m_bs = 2'b11; m_io = 1'b0;
        end
      end else if (q_m_ack) begin
        m_last_data = (m_owner == 2);
        m_owner = 0;
        m_acc = 1'b0; m_wr = 1'b0; m_io = 1'b0;
      end
      if (e_iack) ip = 1'b0;
      if (e_dack) dp = 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
